// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: default
// 640x480 @ 72 Hz mode constants, total-count derivation and the
// coordinate width used for the x/y counters.
package vga_pkg;

  // Width of the x/y coordinate counters; totals must stay below 2**COORD_W.
  localparam int COORD_W = 10;

  // Pixel clock produced by the board PLL for the default mode.
  localparam int PIXEL_CLK_HZ = 31_500_000;

  // Default horizontal timing, in pixels.
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 24;
  localparam int DEF_H_SYNC    = 40;
  localparam int DEF_H_BACK    = 128;

  // Default vertical timing, in lines.
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 9;
  localparam int DEF_V_SYNC    = 3;
  localparam int DEF_V_BACK    = 28;

  // Default renderer pixel-pipeline latency matched by the delay line.
  localparam int DEF_LATENCY = 2;

  // Total period of one axis is the sum of its four regions.
  function automatic int calcTotal(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL = calcTotal(DEF_H_VISIBLE, DEF_H_FRONT,
                                         DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = calcTotal(DEF_V_VISIBLE, DEF_V_FRONT,
                                         DEF_V_SYNC, DEF_V_BACK);

  // Generator state: HOLD parks the raster at (0,0) for the first clock
  // after reset so that cycle presents the origin; RUN free-runs.
  typedef enum logic {
    GEN_HOLD = 1'b0,
    GEN_RUN  = 1'b1
  } genState_e;

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// Parameterised-depth shift register used to re-time one sync/enable
// signal to the renderer's pixel pipeline. Every stage resets to
// RESET_VAL so a reset flushes the line to the inactive level.
module sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH     = DEF_LATENCY,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : gPass
    // A zero-depth line is a plain wire; the clock and reset are unused.
    logic unusedOk;
    assign unusedOk = &{1'b0, clk, reset};
    assign q_o      = d_i;
  end else begin : gShift
    logic [DEPTH-1:0] stage_q;

    // Shift one stage per clock; reset loads the inactive level everywhere.
    always_ff @(posedge clk) begin
      if (reset) begin
        stage_q <= {DEPTH{RESET_VAL}};
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with
// registered hsync/vsync/de/line_start/frame_start decoded from the
// next-state counters (so they always describe the x/y shown in the same
// cycle), plus a delay line re-timing de/hsync/vsync by LATENCY clocks.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic               de_d,
  output logic               hsync_d,
  output logic               vsync_d
);

  localparam int H_TOTAL = calcTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calcTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Counter boundaries in counter width so every compare is width-matched.
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_VIS      = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] Y_VIS      = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  genState_e state_q, state_d;

  logic [COORD_W-1:0] xCount_q, xCount_d;
  logic [COORD_W-1:0] yCount_q, yCount_d;

  logic de_q, de_dn;
  logic hsync_q, hsync_dn;
  logic vsync_q, vsync_dn;
  logic lineStart_q, lineStart_dn;
  logic frameStart_q, frameStart_dn;

  // Next raster position: hold at the origin for the first clock out of
  // reset, then advance x every clock and y on each x wrap.
  always_comb begin
    state_d  = state_q;
    xCount_d = xCount_q;
    yCount_d = yCount_q;
    case (state_q)
      GEN_HOLD: begin
        state_d  = GEN_RUN;
        xCount_d = '0;
        yCount_d = '0;
      end
      GEN_RUN: begin
        if (xCount_q == X_LAST) begin
          xCount_d = '0;
          if (yCount_q == Y_LAST) begin
            yCount_d = '0;
          end else begin
            yCount_d = yCount_q + 1'b1;
          end
        end else begin
          xCount_d = xCount_q + 1'b1;
        end
      end
      default: begin
        state_d  = GEN_HOLD;
        xCount_d = '0;
        yCount_d = '0;
      end
    endcase
  end

  // Decode sync/enable/strobes from the next position so the registered
  // versions line up with the registered counters.
  always_comb begin
    de_dn         = (xCount_d < X_VIS) && (yCount_d < Y_VIS);
    hsync_dn      = ((xCount_d >= HS_START) && (xCount_d < HS_END)) ? HSYNC_POL : !HSYNC_POL;
    vsync_dn      = ((yCount_d >= VS_START) && (yCount_d < VS_END)) ? VSYNC_POL : !VSYNC_POL;
    lineStart_dn  = (xCount_d == '0);
    frameStart_dn = (xCount_d == '0) && (yCount_d == '0);
  end

  // State, counter and output registers; reset parks everything inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= GEN_HOLD;
      xCount_q     <= '0;
      yCount_q     <= '0;
      de_q         <= 1'b0;
      hsync_q      <= !HSYNC_POL;
      vsync_q      <= !VSYNC_POL;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xCount_q     <= xCount_d;
      yCount_q     <= yCount_d;
      de_q         <= de_dn;
      hsync_q      <= hsync_dn;
      vsync_q      <= vsync_dn;
      lineStart_q  <= lineStart_dn;
      frameStart_q <= frameStart_dn;
    end
  end

  assign x           = xCount_q;
  assign y           = yCount_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

  sync_delay #(
    .DEPTH    (LATENCY),
    .RESET_VAL(1'b0)
  ) deDelay (
    .clk  (clk),
    .reset(reset),
    .d_i  (de_q),
    .q_o  (de_d)
  );

  sync_delay #(
    .DEPTH    (LATENCY),
    .RESET_VAL(!HSYNC_POL)
  ) hsyncDelay (
    .clk  (clk),
    .reset(reset),
    .d_i  (hsync_q),
    .q_o  (hsync_d)
  );

  sync_delay #(
    .DEPTH    (LATENCY),
    .RESET_VAL(!VSYNC_POL)
  ) vsyncDelay (
    .clk  (clk),
    .reset(reset),
    .d_i  (vsync_q),
    .q_o  (vsync_d)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share clock and reset:
// A uses the default 640x480@72 timing with LATENCY=2, B a tiny 25x12
// raster with active-high syncs and LATENCY=0, C the same tiny raster
// with active-low syncs and LATENCY=3. Directed expectations are queued
// by the stimulus and consumed by a cycle-indexed monitor, which also
// measures pulse spacings and widths against hand-derived constants.
module tb_vga_timing_gen;

  // Release cycle (first cycle after reset deasserts) and mid-frame reset cycle.
  localparam int R = 6;
  localparam int M = 1970;

  typedef enum int {F_X, F_Y, F_DE, F_HS, F_VS, F_LS, F_FS, F_DED, F_HSD, F_VSD} field_e;

  typedef struct {
    int     cyc;
    int     inst;
    field_e fld;
    int     want;
  } exp_t;

  logic clk;
  logic reset;

  logic [9:0] aX, aY, bX, bY, cX, cY;
  logic aDe, aHs, aVs, aLs, aFs, aDeD, aHsD, aVsD;
  logic bDe, bHs, bVs, bLs, bFs, bDeD, bHsD, bVsD;
  logic cDe, cHs, cVs, cLs, cFs, cDeD, cHsD, cVsD;

  exp_t expQ[$];
  int   totalCnt = 0;
  int   badCnt   = 0;
  int   cyc      = 0;

  vga_timing_gen dutA (
    .clk(clk), .reset(reset), .x(aX), .y(aY), .de(aDe), .hsync(aHs), .vsync(aVs),
    .line_start(aLs), .frame_start(aFs), .de_d(aDeD), .hsync_d(aHsD), .vsync_d(aVsD)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .LATENCY(0)
  ) dutB (
    .clk(clk), .reset(reset), .x(bX), .y(bY), .de(bDe), .hsync(bHs), .vsync(bVs),
    .line_start(bLs), .frame_start(bFs), .de_d(bDeD), .hsync_d(bHsD), .vsync_d(bVsD)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LATENCY(3)
  ) dutC (
    .clk(clk), .reset(reset), .x(cX), .y(cY), .de(cDe), .hsync(cHs), .vsync(cVs),
    .line_start(cLs), .frame_start(cFs), .de_d(cDeD), .hsync_d(cHsD), .vsync_d(cVsD)
  );

  // Free-running clock; first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pick(input int inst, input field_e f);
    logic [31:0] v [10];
    case (inst)
      0: v = '{32'(aX), 32'(aY), 32'(aDe), 32'(aHs), 32'(aVs), 32'(aLs), 32'(aFs), 32'(aDeD), 32'(aHsD), 32'(aVsD)};
      1: v = '{32'(bX), 32'(bY), 32'(bDe), 32'(bHs), 32'(bVs), 32'(bLs), 32'(bFs), 32'(bDeD), 32'(bHsD), 32'(bVsD)};
      default: v = '{32'(cX), 32'(cY), 32'(cDe), 32'(cHs), 32'(cVs), 32'(cLs), 32'(cFs), 32'(cDeD), 32'(cHsD), 32'(cVsD)};
    endcase
    return v[int'(f)];
  endfunction

  function automatic string instName(input int inst);
    case (inst)
      0: return "A";
      1: return "B";
      default: return "C";
    endcase
  endfunction

  // One comparison: count it, and report it when the DUT disagrees.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalCnt++;
    if (got !== want) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic pushExp(input int c, input int inst, input field_e f, input int want);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.fld  = f;
    e.want = want;
    expQ.push_back(e);
  endtask

  // Full set of reset values for one instance; inact is the idle sync level.
  task automatic pushResetRow(input int c, input int inst, input int inact);
    pushExp(c, inst, F_X, 0);     pushExp(c, inst, F_Y, 0);
    pushExp(c, inst, F_DE, 0);    pushExp(c, inst, F_LS, 0);
    pushExp(c, inst, F_FS, 0);    pushExp(c, inst, F_HS, inact);
    pushExp(c, inst, F_VS, inact); pushExp(c, inst, F_DED, 0);
    pushExp(c, inst, F_HSD, inact); pushExp(c, inst, F_VSD, inact);
  endtask

  // Drive reset for n clocks, changing it only on falling edges.
  task automatic applyStimulus(input logic rstVal, input int n);
    repeat (n) begin
      reset = rstVal;
      @(negedge clk);
    end
  endtask

  // Stimulus: reset, free run, one-cycle mid-frame reset, free run.
  initial begin
    reset = 1'b1;

    // Reset hold, release and first lines / first tiny frame (cycle order).
    pushResetRow(3, 0, 1); pushResetRow(3, 1, 0); pushResetRow(3, 2, 1);
    pushExp(5, 0, F_DE, 0); pushExp(5, 0, F_LS, 0);
    pushExp(R, 0, F_X, 0); pushExp(R, 0, F_Y, 0); pushExp(R, 0, F_DE, 1);
    pushExp(R, 0, F_LS, 1); pushExp(R, 0, F_FS, 1); pushExp(R, 0, F_DED, 0); pushExp(R, 0, F_HS, 1);
    pushExp(R, 1, F_DE, 1); pushExp(R, 1, F_DED, 1); pushExp(R, 1, F_LS, 1);
    pushExp(R, 1, F_FS, 1); pushExp(R, 1, F_HSD, 0);
    pushExp(R+1, 0, F_X, 1); pushExp(R+1, 0, F_LS, 0); pushExp(R+1, 0, F_FS, 0); pushExp(R+1, 0, F_DED, 0);
    pushExp(R+2, 0, F_DED, 1); pushExp(R+2, 2, F_DED, 0);
    pushExp(R+3, 2, F_DED, 1);
    pushExp(R+16, 1, F_X, 16); pushExp(R+16, 1, F_DE, 0); pushExp(R+16, 1, F_DED, 0);
    pushExp(R+18, 1, F_HS, 1); pushExp(R+18, 1, F_HSD, 1); pushExp(R+18, 2, F_HS, 0); pushExp(R+18, 2, F_DED, 1);
    pushExp(R+19, 2, F_DED, 0);
    pushExp(R+20, 2, F_HSD, 1);
    pushExp(R+21, 1, F_HS, 0); pushExp(R+21, 1, F_HSD, 0); pushExp(R+21, 2, F_HSD, 0);
    pushExp(R+150, 1, F_Y, 6); pushExp(R+150, 1, F_DE, 0); pushExp(R+150, 1, F_LS, 1);
    pushExp(R+174, 1, F_VS, 0);
    pushExp(R+175, 1, F_Y, 7); pushExp(R+175, 1, F_VS, 1); pushExp(R+175, 1, F_VSD, 1);
    pushExp(R+177, 2, F_VSD, 1);
    pushExp(R+178, 2, F_VSD, 0);
    pushExp(R+224, 1, F_VS, 1);
    pushExp(R+225, 1, F_Y, 9); pushExp(R+225, 1, F_VS, 0);
    pushExp(R+299, 1, F_X, 24); pushExp(R+299, 1, F_Y, 11);
    pushExp(R+300, 1, F_X, 0); pushExp(R+300, 1, F_Y, 0); pushExp(R+300, 1, F_LS, 1);
    pushExp(R+300, 1, F_FS, 1); pushExp(R+300, 1, F_VS, 0); pushExp(R+300, 1, F_DE, 1);
    pushExp(R+639, 0, F_X, 639); pushExp(R+639, 0, F_DE, 1);
    pushExp(R+640, 0, F_DE, 0);
    pushExp(R+663, 0, F_HS, 1);
    pushExp(R+664, 0, F_X, 664); pushExp(R+664, 0, F_HS, 0);
    pushExp(R+665, 0, F_HSD, 1);
    pushExp(R+666, 0, F_HSD, 0);
    pushExp(R+703, 0, F_HS, 0);
    pushExp(R+704, 0, F_HS, 1);
    pushExp(R+705, 0, F_HSD, 0);
    pushExp(R+706, 0, F_HSD, 1);
    pushExp(R+831, 0, F_X, 831); pushExp(R+831, 0, F_Y, 0); pushExp(R+831, 0, F_LS, 0);
    pushExp(R+832, 0, F_X, 0); pushExp(R+832, 0, F_Y, 1); pushExp(R+832, 0, F_LS, 1);
    pushExp(R+832, 0, F_FS, 0); pushExp(R+832, 0, F_DE, 1);

    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 995);

    // Mid-frame reset: A sits at x=300,y=2 in cycle M; reset hits edge M+1.
    pushExp(M, 0, F_X, 300); pushExp(M, 0, F_Y, 2); pushExp(M, 0, F_DE, 1);
    pushResetRow(M+1, 0, 1);
    pushExp(M+1, 1, F_X, 0); pushExp(M+1, 1, F_Y, 0); pushExp(M+1, 1, F_DE, 0); pushExp(M+1, 1, F_DED, 0);
    pushExp(M+1, 2, F_DED, 0); pushExp(M+1, 2, F_VSD, 1);
    pushExp(M+2, 0, F_X, 0); pushExp(M+2, 0, F_Y, 0); pushExp(M+2, 0, F_LS, 1);
    pushExp(M+2, 0, F_FS, 1); pushExp(M+2, 0, F_DE, 1); pushExp(M+2, 0, F_DED, 0);
    pushExp(M+2, 1, F_FS, 1); pushExp(M+2, 2, F_DED, 0);
    pushExp(M+3, 0, F_X, 1); pushExp(M+3, 0, F_FS, 0); pushExp(M+3, 0, F_DED, 0);
    pushExp(M+4, 0, F_DED, 1); pushExp(M+4, 2, F_DED, 0);
    pushExp(M+5, 2, F_DED, 1);
    pushExp(M+302, 1, F_X, 0); pushExp(M+302, 1, F_Y, 0); pushExp(M+302, 1, F_FS, 1); pushExp(M+302, 1, F_LS, 1);

    applyStimulus(1'b0, M - 1000);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 320);
    @(negedge clk);
    finalChecks();
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

  // Measurement state for spacing and width checks.
  int   aLsLast = -1, aLsIntervals = 0;
  int   aHsRun = 0, aHsRuns = 0, aDeRun = 0, aDeRuns = 0;
  bit   aHsValid = 0, aDeValid = 0;
  logic aHsPrev, aDePrev;
  int   bFsLast = -1, bFsIntervals = 0;
  int   bVsRun = 0, bVsRuns = 0;
  bit   bVsValid = 0;
  logic bVsPrev;

  task automatic finalChecks();
    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("A line_start intervals", aLsIntervals, 2);
    checkOutput("A hsync pulses", aHsRuns, 2);
    checkOutput("A de runs", aDeRuns, 2);
    checkOutput("B frame_start intervals", bFsIntervals, 7);
    checkOutput("B vsync pulses", bVsRuns, 7);
  endtask

  // Monitor: sample #1 after each rising edge, retire due expectations,
  // and measure pulse spacings/widths between resets.
  initial begin
    exp_t  e;
    logic  rstEdge;
    forever begin
      @(posedge clk);
      rstEdge = reset;
      cyc++;
      #1;
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
        e = expQ.pop_front();
        if (e.cyc < cyc) begin
          totalCnt++;
          badCnt++;
          $display("[TB] FAIL stale expectation %s.%s@%0d: got none want %0d", instName(e.inst), e.fld.name(), e.cyc, e.want);
        end else begin
          checkOutput($sformatf("%s.%s@%0d", instName(e.inst), e.fld.name(), e.cyc), pick(e.inst, e.fld), e.want);
        end
      end

      if (rstEdge) begin
        aLsLast  = -1;
        aHsValid = 0;
        aDeValid = 0;
        bFsLast  = -1;
        bVsValid = 0;
      end else begin
        if (aLs === 1'b1) begin
          if (aLsLast >= 0) begin
            checkOutput("A line_start period", cyc - aLsLast, 832);
            aLsIntervals++;
          end
          aLsLast = cyc;
        end
        if (aHs === 1'b0) begin
          if (aHsPrev !== 1'b0) begin
            aHsValid = 1;
            aHsRun   = 0;
            checkOutput("A hsync start x", 32'(aX), 664);
          end
          aHsRun++;
        end else if (aHsPrev === 1'b0 && aHsValid) begin
          checkOutput("A hsync width", aHsRun, 40);
          aHsRuns++;
          aHsValid = 0;
        end
        if (aDe === 1'b1) begin
          if (aDePrev !== 1'b1) begin
            aDeValid = 1;
            aDeRun   = 0;
          end
          aDeRun++;
        end else if (aDePrev === 1'b1 && aDeValid) begin
          checkOutput("A de width", aDeRun, 640);
          aDeRuns++;
          aDeValid = 0;
        end
        if (bFs === 1'b1) begin
          if (bFsLast >= 0) begin
            checkOutput("B frame_start period", cyc - bFsLast, 300);
            bFsIntervals++;
          end
          bFsLast = cyc;
        end
        if (bVs === 1'b1) begin
          if (bVsPrev !== 1'b1) begin
            bVsValid = 1;
            bVsRun   = 0;
            checkOutput("B vsync start y", 32'(bY), 7);
          end
          bVsRun++;
        end else if (bVsPrev === 1'b1 && bVsValid) begin
          checkOutput("B vsync width", bVsRun, 50);
          bVsRuns++;
          bVsValid = 0;
        end
        if (bY >= 10'd6) begin
          checkOutput("B de on blank line", 32'(bDe), 0);
        end
      end
      aHsPrev = aHs;
      aDePrev = aDe;
      bVsPrev = bVs;
    end
  end

endmodule
